// File: rtl/read_command_responder_pkg.sv
// Shared CAPI types for the CU read-command responder: command/data/response lines,
// PSL response codes and bus widths.
package read_command_responder_pkg;

   localparam int unsigned TAG_WIDTH              = 8;
   localparam int unsigned PSL_DATA_WIDTH         = 512;
   localparam int unsigned PSL_COMMAND_WIDTH      = 13;
   localparam int unsigned PSL_ADDRESS_WIDTH      = 64;
   localparam int unsigned PSL_SIZE_WIDTH         = 12;
   localparam int unsigned PSL_RESPONSE_WIDTH     = 8;
   localparam int unsigned CU_ID_WIDTH            = 8;
   localparam int unsigned CACHELINE_OFFSET_WIDTH = 7;

   localparam logic [PSL_RESPONSE_WIDTH-1:0] DONE    = 8'h00;
   localparam logic [PSL_RESPONSE_WIDTH-1:0] FLUSHED = 8'h06;
   localparam logic [PSL_RESPONSE_WIDTH-1:0] PAGED   = 8'h0A;

   typedef enum logic [2:0] {
      STRUCT_INVALID,
      INV_EDGE_ARRAY_SRC,
      INV_EDGE_ARRAY_DEST,
      INV_EDGE_ARRAY_WEIGHT,
      INV_VERTEX_DATA_READ
   } vertex_struct_type;

   typedef struct packed {
      logic [CU_ID_WIDTH-1:0]            cu_id;
      vertex_struct_type                 vertex_struct;
      logic [PSL_SIZE_WIDTH-1:0]         real_size;
      logic [CACHELINE_OFFSET_WIDTH-1:0] cacheline_offest;
   } cmd_payload_t;

   typedef struct packed {
      logic [PSL_COMMAND_WIDTH-1:0] command;
      logic [PSL_ADDRESS_WIDTH-1:0] address;
      logic [PSL_SIZE_WIDTH-1:0]    size;
   } cmd_request_t;

   typedef struct packed {
      logic                         valid;
      logic [PSL_COMMAND_WIDTH-1:0] command;
      logic [PSL_ADDRESS_WIDTH-1:0] address;
      logic [PSL_SIZE_WIDTH-1:0]    size;
      cmd_payload_t                 cmd;
   } CommandBufferLine;

   typedef struct packed {
      logic                      valid;
      cmd_payload_t              cmd;
      logic [PSL_DATA_WIDTH-1:0] data;
   } ReadWriteDataLine;

   typedef struct packed {
      logic                          valid;
      cmd_payload_t                  cmd;
      logic [PSL_RESPONSE_WIDTH-1:0] response;
   } ResponseBufferLine;

   // Responses that leave the tag live and ask for the command to be reissued.
   function automatic logic is_retry_response(input logic [PSL_RESPONSE_WIDTH-1:0] code);
      return (code == PAGED) || (code == FLUSHED);
   endfunction

endpackage

// File: rtl/read_command_responder_tag_allocator.sv
// PSL tag allocator: busy bitmap, lowest-free-index encoder and registered busy count.
module read_command_responder_tag_allocator
   import read_command_responder_pkg::*;
#(
   parameter int unsigned TAG_COUNT = 32,
   localparam int unsigned IDX_W = $clog2(TAG_COUNT),
   localparam int unsigned CNT_W = IDX_W + 1
) (
   input  logic                 clock,
   input  logic                 rstn,
   input  logic                 alloc,
   input  logic                 free,
   input  logic [IDX_W-1:0]     free_idx,
   output logic                 any_free_c,
   output logic [IDX_W-1:0]     alloc_idx_c,
   output logic [TAG_COUNT-1:0] busy,
   output logic [CNT_W-1:0]     count
);

   logic [TAG_COUNT-1:0] busy_next_c;
   logic [CNT_W-1:0]     count_next_c;

   // Lowest free index, taken from the start-of-cycle bitmap only.
   always_comb begin
      any_free_c  = 1'b0;
      alloc_idx_c = '0;
      for (int i = TAG_COUNT - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            any_free_c  = 1'b1;
            alloc_idx_c = IDX_W'(i);
         end
      end
   end

   always_comb begin
      busy_next_c = busy;
      if (alloc && any_free_c) busy_next_c[alloc_idx_c] = 1'b1;
      if (free)                busy_next_c[free_idx]    = 1'b0;
      count_next_c = '0;
      for (int i = 0; i < TAG_COUNT; i++) begin
         count_next_c = count_next_c + CNT_W'(busy_next_c[i]);
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         busy  <= '0;
         count <= '0;
      end else begin
         busy  <= busy_next_c;
         count <= count_next_c;
      end
   end

endmodule

// File: rtl/read_command_responder.sv
// PSL-side responder for CU read commands: tags commands onto the PSL, then returns data
// halves and responses re-tagged with the originating cmd payload.
// Optional READ_RESPONDER_RETRY_EN: PAGED/FLUSHED responses requeue and reissue the tag.
module read_command_responder
   import read_command_responder_pkg::*;
#(
   parameter int unsigned TAG_COUNT = 32,
   parameter int unsigned CREDITS   = 16
) (
   input  logic                          clock,
   input  logic                          rstn,
   input  CommandBufferLine              command_in,
   output logic                          command_ready,
   output logic                          ah_cvalid,
   output logic [PSL_COMMAND_WIDTH-1:0]  ah_com,
   output logic [PSL_ADDRESS_WIDTH-1:0]  ah_cea,
   output logic [PSL_SIZE_WIDTH-1:0]     ah_csize,
   output logic [TAG_WIDTH-1:0]          ah_ctag,
   input  logic                          ha_bwvalid,
   input  logic [TAG_WIDTH-1:0]          ha_bwtag,
   input  logic [5:0]                    ha_bwad,
   input  logic [PSL_DATA_WIDTH-1:0]     ha_bwdata,
   input  logic                          ha_rvalid,
   input  logic [TAG_WIDTH-1:0]          ha_rtag,
   input  logic [PSL_RESPONSE_WIDTH-1:0] ha_response,
   output ReadWriteDataLine              read_data_0_out,
   output ReadWriteDataLine              read_data_1_out,
   output ResponseBufferLine             response_out,
   output logic [8:0]                    tags_outstanding,
   output logic                          tag_error
);

   localparam int unsigned IDX_W     = $clog2(TAG_COUNT);
   localparam int unsigned CNT_W     = IDX_W + 1;
   localparam int unsigned CRED_W    = $clog2(CREDITS + 1);
   localparam int unsigned TAG_EXT_W = TAG_WIDTH + 1;
   localparam logic [CRED_W-1:0]    CREDIT_MAX = CRED_W'(CREDITS);
   localparam logic [TAG_EXT_W-1:0] TAG_LIMIT  = TAG_EXT_W'(TAG_COUNT);

   cmd_payload_t         cmd_table [TAG_COUNT];
   logic [CRED_W-1:0]    credit;
   logic [CRED_W-1:0]    credit_next_c;
   logic                 any_free_c;
   logic [IDX_W-1:0]     alloc_idx_c;
   logic [TAG_COUNT-1:0] busy;
   logic [CNT_W-1:0]     busy_count;

   logic [IDX_W-1:0] bw_idx_c;
   logic [IDX_W-1:0] r_idx_c;
   logic             bw_hit_c;
   logic             r_hit_c;
   logic             accept_c;
   logic             free_c;
   logic             retry_resp_c;
   logic             reissue_c;
   logic             issue_valid_c;
   cmd_request_t     issue_req_c;
   logic [IDX_W-1:0] issue_tag_c;
   logic             unused_bwad_c;

   assign bw_idx_c      = ha_bwtag[IDX_W-1:0];
   assign r_idx_c       = ha_rtag[IDX_W-1:0];
   assign bw_hit_c      = ha_bwvalid && ({1'b0, ha_bwtag} < TAG_LIMIT) && busy[bw_idx_c];
   assign r_hit_c       = ha_rvalid  && ({1'b0, ha_rtag}  < TAG_LIMIT) && busy[r_idx_c];
   assign accept_c      = command_in.valid && command_ready;
   assign free_c        = r_hit_c && !retry_resp_c;
   assign unused_bwad_c = ^ha_bwad[5:1];

   read_command_responder_tag_allocator #(
      .TAG_COUNT (TAG_COUNT)
   ) u_tag_allocator (
      .clock       (clock),
      .rstn        (rstn),
      .alloc       (accept_c),
      .free        (free_c),
      .free_idx    (r_idx_c),
      .any_free_c  (any_free_c),
      .alloc_idx_c (alloc_idx_c),
      .busy        (busy),
      .count       (busy_count)
   );

   assign tags_outstanding = 9'(busy_count);

`ifdef READ_RESPONDER_RETRY_EN
   cmd_request_t     req_table  [TAG_COUNT];
   logic [IDX_W-1:0] retry_fifo [TAG_COUNT];
   logic [IDX_W-1:0] retry_wr_ptr;
   logic [IDX_W-1:0] retry_rd_ptr;
   logic [CNT_W-1:0] retry_count;
   logic             retry_pending_c;
   logic             retry_push_c;

   assign retry_pending_c = (retry_count != '0);
   assign retry_resp_c    = r_hit_c && is_retry_response(ha_response);
   assign retry_push_c    = retry_resp_c && (retry_count != CNT_W'(TAG_COUNT));
   assign reissue_c       = retry_pending_c && (credit != '0);
   assign command_ready   = (credit != '0) && any_free_c && !retry_pending_c;

   // Reissues replay the stored request under the same tag and win over new commands.
   always_comb begin
      issue_valid_c = accept_c || reissue_c;
      issue_req_c   = '{command: command_in.command, address: command_in.address,
                        size: command_in.size};
      issue_tag_c   = alloc_idx_c;
      if (reissue_c) begin
         issue_req_c = req_table[retry_fifo[retry_rd_ptr]];
         issue_tag_c = retry_fifo[retry_rd_ptr];
      end
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         retry_wr_ptr <= '0;
         retry_rd_ptr <= '0;
         retry_count  <= '0;
      end else begin
         if (retry_push_c) retry_wr_ptr <= retry_wr_ptr + IDX_W'(1);
         if (reissue_c)    retry_rd_ptr <= retry_rd_ptr + IDX_W'(1);
         retry_count <= retry_count + CNT_W'(retry_push_c) - CNT_W'(reissue_c);
      end
   end

   always_ff @(posedge clock) begin
      if (retry_push_c) retry_fifo[retry_wr_ptr] <= r_idx_c;
      if (accept_c) begin
         req_table[alloc_idx_c] <= '{command: command_in.command, address: command_in.address,
                                     size: command_in.size};
      end
   end
`else
   assign retry_resp_c  = 1'b0;
   assign reissue_c     = 1'b0;
   assign command_ready = (credit != '0) && any_free_c;
   assign issue_valid_c = accept_c;
   assign issue_req_c   = '{command: command_in.command, address: command_in.address,
                            size: command_in.size};
   assign issue_tag_c   = alloc_idx_c;
`endif

   // Every live response returns its credit; a PSL issue consumes one. Saturates both ways.
   always_comb begin
      credit_next_c = credit;
      if (issue_valid_c && !r_hit_c) begin
         if (credit != '0) credit_next_c = credit - CRED_W'(1);
      end else if (r_hit_c && !issue_valid_c) begin
         if (credit != CREDIT_MAX) credit_next_c = credit + CRED_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (accept_c) cmd_table[alloc_idx_c] <= command_in.cmd;
   end

   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         credit          <= CREDIT_MAX;
         ah_cvalid       <= 1'b0;
         ah_com          <= '0;
         ah_cea          <= '0;
         ah_csize        <= '0;
         ah_ctag         <= '0;
         read_data_0_out <= '0;
         read_data_1_out <= '0;
         response_out    <= '0;
         tag_error       <= 1'b0;
      end else begin
         credit    <= credit_next_c;
         ah_cvalid <= issue_valid_c;
         ah_com    <= issue_valid_c ? issue_req_c.command : '0;
         ah_cea    <= issue_valid_c ? issue_req_c.address : '0;
         ah_csize  <= issue_valid_c ? issue_req_c.size    : '0;
         ah_ctag   <= issue_valid_c ? TAG_WIDTH'(issue_tag_c) : '0;

         read_data_0_out <= '0;
         read_data_1_out <= '0;
         if (bw_hit_c && !ha_bwad[0]) begin
            read_data_0_out <= '{valid: 1'b1, cmd: cmd_table[bw_idx_c], data: ha_bwdata};
         end
         if (bw_hit_c && ha_bwad[0]) begin
            read_data_1_out <= '{valid: 1'b1, cmd: cmd_table[bw_idx_c], data: ha_bwdata};
         end

         response_out <= '0;
         if (free_c) begin
            response_out <= '{valid: 1'b1, cmd: cmd_table[r_idx_c], response: ha_response};
         end

         if ((ha_bwvalid && !bw_hit_c) || (ha_rvalid && !r_hit_c)) tag_error <= 1'b1;
      end
   end

endmodule
